// File: rtl/mau_pkg.sv
// Shared types and widths for the MAU BSRAM read path.
package mau_pkg;

    localparam int MAU_ADDR_W = 10;
    localparam int MAU_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mau_state_e;

    typedef struct packed {
        logic [MAU_DATA_W-1:0] data;
        logic                  eol;
        logic                  last;
    } mau_word_t;

endpackage

// File: rtl/mau_bsram_reader_if.sv
// Row-major tile stream from the BSRAM reader to the MAU datapath.
interface mau_bsram_reader_if #(
    parameter int DATA_W = mau_pkg::MAU_DATA_W
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_eol;
    logic              m_last;

    modport master (output m_valid, m_data, m_eol, m_last, input m_ready);
    modport slave  (input m_valid, m_data, m_eol, m_last, output m_ready);
endinterface

// File: rtl/mau_stream_fifo.sv
// Small register-based synchronous FIFO; head word is read straight from storage.
module mau_stream_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Empty FIFO presents zeros so the stream fields read 0 whenever not valid.
    assign empty_o    = (count_q == '0);
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/mau_bsram_reader.sv
// Read-side initiator for one BSRAM port: walks a tile row-major and streams it out.
//
//  state | meaning
//  IDLE  | waiting for start
//  RUN   | issuing reads while credit allows
//  DRAIN | all reads issued, waiting for FIFO and in-flight read to empty
//  DONE  | one-cycle done pulse
module mau_bsram_reader
    import mau_pkg::*;
#(
    parameter int ADDR_W     = MAU_ADDR_W,
    parameter int DATA_W     = MAU_DATA_W,
    parameter int DIM_W      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [DIM_W-1:0]  rows_i,
    input  logic [DIM_W-1:0]  cols_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              ram_ce_o,
    output logic              ram_oce_o,
    output logic              ram_wre_o,
    output logic [ADDR_W-1:0] ram_ad_o,
    output logic [DATA_W-1:0] ram_din_o,
    output logic              ram_reset_o,
    input  logic [DATA_W-1:0] ram_dout_i,
    mau_bsram_reader_if.master m_if
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    mau_state_e        state_q, state_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  rows_q, rows_d;
    logic [DIM_W-1:0]  cols_q, cols_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic              inflight_q, infl_eol_q, infl_last_q;

    logic              issue, done;
    logic              last_col, last_row;
    logic              credit_ok;
    logic [CNT_W:0]    outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty, pop;
    logic [DATA_W+1:0] fifo_out;

    assign last_col    = (col_q == cols_q - DIM_W'(1));
    assign last_row    = (row_q == rows_q - DIM_W'(1));
    assign outstanding = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    assign credit_ok   = (outstanding < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        state_d    = state_q;
        row_addr_d = row_addr_q;
        col_d      = col_q;
        row_d      = row_q;
        rows_d     = rows_q;
        cols_d     = cols_q;
        stride_d   = stride_q;
        issue      = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    rows_d     = rows_i;
                    cols_d     = cols_i;
                    stride_d   = stride_i;
                    row_addr_d = base_i;
                    col_d      = '0;
                    row_d      = '0;
                    state_d    = (rows_i == '0 || cols_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (last_col) begin
                        col_d      = '0;
                        row_addr_d = row_addr_q + stride_q;
                        row_d      = row_q + DIM_W'(1);
                        if (last_row) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        col_d = col_q + DIM_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Leaving on the pop of the final word makes done follow it by one cycle.
                if (!inflight_q && (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_addr_q  <= '0;
            col_q       <= '0;
            row_q       <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            stride_q    <= '0;
            inflight_q  <= 1'b0;
            infl_eol_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_addr_q  <= row_addr_d;
            col_q       <= col_d;
            row_q       <= row_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            stride_q    <= stride_d;
            inflight_q  <= issue;
            infl_eol_q  <= issue & last_col;
            infl_last_q <= issue & last_col & last_row;
        end
    end

    assign pop = ~fifo_empty & m_if.m_ready;

    mau_stream_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i ({ram_dout_i, infl_eol_q, infl_last_q}),
        .pop_i       (pop),
        .pop_data_o  (fifo_out),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign m_if.m_valid = ~fifo_empty;
    assign m_if.m_data  = fifo_out[DATA_W+1:2];
    assign m_if.m_eol   = fifo_out[1];
    assign m_if.m_last  = fifo_out[0];

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = done;
    assign ram_ce_o    = issue;
    assign ram_oce_o   = issue;
    assign ram_wre_o   = 1'b0;
    assign ram_ad_o    = issue ? row_addr_q + ADDR_W'(col_q) : '0;
    assign ram_din_o   = '0;
    assign ram_reset_o = reset;

endmodule

// File: tb/tb_mau_bsram_reader.sv
// Bench for mau_bsram_reader: BSRAM model, tile reference model and scenario tasks.
module tb_mau_bsram_reader;
    import mau_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DIM_W  = 6;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base = '0;
    logic [ADDR_W-1:0] stride = '0;
    logic [DIM_W-1:0]  rows = '0;
    logic [DIM_W-1:0]  cols = '0;
    logic              busy, done, ram_ce, ram_oce, ram_wre, ram_reset;
    logic [ADDR_W-1:0] ram_ad;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout = '0;

    always #5 clk = ~clk;

    mau_bsram_reader_if #(.DATA_W(DATA_W)) m_if ();

    mau_bsram_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start_i(start), .base_i(base), .rows_i(rows),
        .cols_i(cols), .stride_i(stride), .busy_o(busy), .done_o(done),
        .ram_ce_o(ram_ce), .ram_oce_o(ram_oce), .ram_wre_o(ram_wre), .ram_ad_o(ram_ad),
        .ram_din_o(ram_din), .ram_reset_o(ram_reset), .ram_dout_i(ram_dout), .m_if(m_if)
    );

    // BSRAM port: registered read, data one cycle after the strobe
    logic [DATA_W-1:0] mem [1024];
    always @(posedge clk) if (ram_ce) ram_dout <= mem[ram_ad];

    int checks = 0;
    int errors = 0;

    int                exp_addr[$];
    logic [DATA_W+1:0] exp_word[$];
    int                obs_addr[$];
    logic [DATA_W+1:0] obs_word[$];
    int done_cyc, done_cnt, first_ce, first_valid, last_xfer;
    int credit_viol, stable_viol, eol_viol, busy_bad, ce_after_done, static_bad;

    // Reference: element (r,c) lives at (base + r*stride + c) mod 1024
    task automatic build_expected(input int b, input int r, input int c, input int s);
        exp_addr.delete();
        exp_word.delete();
        for (int rr = 0; rr < r; rr++) begin
            for (int cc = 0; cc < c; cc++) begin
                int a;
                a = (b + rr * s + cc) % 1024;
                exp_addr.push_back(a);
                exp_word.push_back({mem[a], cc == c - 1, (cc == c - 1) && (rr == r - 1)});
            end
        end
    endtask

    function automatic int addr_diffs();
        int n;
        int m;
        n = (obs_addr.size() > exp_addr.size()) ? obs_addr.size() - exp_addr.size()
                                                : exp_addr.size() - obs_addr.size();
        m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
        for (int i = 0; i < m; i++) if (obs_addr[i] != exp_addr[i]) n++;
        return n;
    endfunction

    function automatic int word_diffs();
        int n;
        int m;
        n = (obs_word.size() > exp_word.size()) ? obs_word.size() - exp_word.size()
                                                : exp_word.size() - obs_word.size();
        m = (obs_word.size() < exp_word.size()) ? obs_word.size() : exp_word.size();
        for (int i = 0; i < m; i++) if (obs_word[i] !== exp_word[i]) n++;
        return n;
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    // Drives one command and records what the DUT did, cycle by cycle.
    task automatic run_tile(input int b, input int r, input int c, input int s,
                            input int mode, input bit inject);
        int cyc = 0, issued = 0, xfers = 0;
        bit prev_stall = 1'b0;
        logic [DATA_W+1:0] prev_w = '0, cur_w;
        obs_addr.delete();
        obs_word.delete();
        done_cyc = -1; done_cnt = 0; first_ce = -1; first_valid = -1; last_xfer = -1;
        credit_viol = 0; stable_viol = 0; eol_viol = 0; busy_bad = 0;
        ce_after_done = 0; static_bad = 0;
        @(posedge clk); #1;
        base = ADDR_W'(b); rows = DIM_W'(r); cols = DIM_W'(c); stride = ADDR_W'(s);
        start = 1'b1;
        m_if.m_ready = ready_for(mode, 0);
        forever begin
            @(negedge clk);
            if (ram_oce !== ram_ce || ram_wre !== 1'b0 || ram_din !== '0 || ram_reset !== reset)
                static_bad++;
            if (ram_ce) begin
                if (first_ce < 0) first_ce = cyc;
                if (issued - xfers >= DEPTH) credit_viol++;
                if (done_cyc >= 0) ce_after_done++;
                obs_addr.push_back(int'(ram_ad));
                issued++;
            end
            cur_w = {m_if.m_data, m_if.m_eol, m_if.m_last};
            if (prev_stall && (!m_if.m_valid || cur_w !== prev_w)) stable_viol++;
            if (m_if.m_valid && m_if.m_last && !m_if.m_eol) eol_viol++;
            if (m_if.m_valid && first_valid < 0) first_valid = cyc;
            if (m_if.m_valid && m_if.m_ready) begin
                obs_word.push_back(cur_w);
                xfers++;
                last_xfer = cyc;
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_w = cur_w;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc == 0 && busy !== 1'b0) busy_bad++;
            if (cyc >= 1 && (done_cyc < 0 || cyc == done_cyc) && busy !== 1'b1) busy_bad++;
            if (done_cyc >= 0 && cyc > done_cyc && busy !== 1'b0) busy_bad++;
            if ((done_cyc >= 0 && cyc >= done_cyc + 3) || cyc >= 2000) break;
            @(posedge clk); #1;
            cyc++;
            start = inject && (cyc == 4);
            if (inject && cyc == 4) base = ADDR_W'(b) ^ 10'h155;
            m_if.m_ready = ready_for(mode, cyc);
        end
        start = 1'b0;
        m_if.m_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({busy, done, ram_ce, ram_oce, m_if.m_valid, m_if.m_eol, m_if.m_last} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b required 0000000",
                     {busy, done, ram_ce, ram_oce, m_if.m_valid, m_if.m_eol, m_if.m_last});
        end
        checks++;
        if (ram_ad !== '0 || m_if.m_data !== '0 || ram_reset !== 1'b1) begin
            errors++;
            $display("FAIL reset_buses got ad=%0d data=%0d ram_reset=%b required 0 0 1",
                     ram_ad, m_if.m_data, ram_reset);
        end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        build_expected(0, 2, 3, 4);
        run_tile(0, 2, 3, 4, 0, 0);
        checks++;
        if (addr_diffs() !== 0) begin
            errors++; $display("FAIL basic_addr got %0d diffs (%0d reads) required 0", addr_diffs(), obs_addr.size());
        end
        checks++;
        if (word_diffs() !== 0) begin
            errors++; $display("FAIL basic_words got %0d diffs (%0d words) required 0", word_diffs(), obs_word.size());
        end
        checks++;
        if (first_ce !== 1 || first_valid !== 3) begin
            errors++; $display("FAIL basic_latency got ce@%0d valid@%0d required ce@1 valid@3", first_ce, first_valid);
        end
        checks++;
        if (done_cyc !== 9 || done_cnt !== 1) begin
            errors++; $display("FAIL basic_done got cycle %0d count %0d required cycle 9 count 1", done_cyc, done_cnt);
        end
        checks++;
        if (busy_bad !== 0 || static_bad !== 0 || eol_viol !== 0) begin
            errors++; $display("FAIL basic_misc got busy=%0d static=%0d eol=%0d required 0 0 0", busy_bad, static_bad, eol_viol);
        end
    endtask

    task automatic test_backpressure();
        build_expected(0, 2, 3, 4);
        run_tile(0, 2, 3, 4, 1, 0);
        checks++;
        if (word_diffs() !== 0 || addr_diffs() !== 0) begin
            errors++; $display("FAIL bp_words got %0d/%0d diffs required 0/0", word_diffs(), addr_diffs());
        end
        checks++;
        if (credit_viol !== 0 || stable_viol !== 0) begin
            errors++; $display("FAIL bp_flow got credit=%0d stable=%0d required 0 0", credit_viol, stable_viol);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== last_xfer + 1) begin
            errors++; $display("FAIL bp_done got cycle %0d count %0d required cycle %0d count 1", done_cyc, done_cnt, last_xfer + 1);
        end
    endtask

    task automatic test_wrap();
        build_expected(1022, 1, 4, 7);
        run_tile(1022, 1, 4, 7, 0, 0);
        checks++;
        if (addr_diffs() !== 0) begin
            errors++; $display("FAIL wrap_addr got %0d diffs (%0d reads) required 0", addr_diffs(), obs_addr.size());
        end
        checks++;
        if (word_diffs() !== 0 || done_cnt !== 1) begin
            errors++; $display("FAIL wrap_words got %0d diffs done=%0d required 0 1", word_diffs(), done_cnt);
        end
    endtask

    task automatic test_empty();
        run_tile(100, 0, 5, 3, 0, 0);
        checks++;
        if (obs_addr.size() !== 0 || first_valid !== -1) begin
            errors++; $display("FAIL empty_noread got reads=%0d valid@%0d required 0 -1", obs_addr.size(), first_valid);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc < 1 || done_cyc > 2) begin
            errors++; $display("FAIL empty_done got cycle %0d count %0d required cycle 1..2 count 1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        @(posedge clk); #1;
        base = 10'd200; rows = 6'd2; cols = 6'd4; stride = 10'd9;
        start = 1'b1;
        m_if.m_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        // three words buffered and the fourth read in flight at this point
        checks++;
        if (m_if.m_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre got valid=%b busy=%b required 1 1", m_if.m_valid, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, ram_ce, ram_oce, m_if.m_valid, m_if.m_eol, m_if.m_last} !== 7'b0 ||
            ram_ad !== '0 || m_if.m_data !== '0) begin
            errors++; $display("FAIL rstmid_outputs got flags=%b ad=%0d data=%0d required 0",
                {busy, done, ram_ce, ram_oce, m_if.m_valid, m_if.m_eol, m_if.m_last}, ram_ad, m_if.m_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        m_if.m_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done || m_if.m_valid || ram_ce || busy) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL rstmid_quiet got %0d active cycles required 0", bad);
        end
    endtask

    task automatic test_after_reset();
        build_expected(500, 3, 2, 40);
        run_tile(500, 3, 2, 40, 0, 0);
        checks++;
        if (addr_diffs() !== 0 || word_diffs() !== 0 || done_cnt !== 1) begin
            errors++; $display("FAIL after_reset got %0d/%0d diffs done=%0d required 0/0 1", addr_diffs(), word_diffs(), done_cnt);
        end
    endtask

    task automatic test_start_ignored();
        build_expected(300, 3, 3, 17);
        run_tile(300, 3, 3, 17, 0, 1);
        checks++;
        if (addr_diffs() !== 0 || word_diffs() !== 0) begin
            errors++; $display("FAIL ignore_tile got %0d/%0d diffs required 0/0", addr_diffs(), word_diffs());
        end
        checks++;
        if (done_cnt !== 1 || ce_after_done !== 0) begin
            errors++; $display("FAIL ignore_done got done=%0d extra_reads=%0d required 1 0", done_cnt, ce_after_done);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            int b, r, c, s;
            b = $urandom_range(0, 1023);
            r = $urandom_range(1, 5);
            c = $urandom_range(1, 6);
            s = $urandom_range(0, 1023);
            build_expected(b, r, c, s);
            run_tile(b, r, c, s, 2, 0);
            checks++;
            if (addr_diffs() !== 0 || word_diffs() !== 0) begin
                errors++; $display("FAIL rand%0d_data got %0d/%0d diffs required 0/0 (b=%0d r=%0d c=%0d s=%0d)",
                                   t, addr_diffs(), word_diffs(), b, r, c, s);
            end
            checks++;
            if (credit_viol !== 0 || stable_viol !== 0 || eol_viol !== 0 || busy_bad !== 0) begin
                errors++; $display("FAIL rand%0d_rules got credit=%0d stable=%0d eol=%0d busy=%0d required 0",
                                   t, credit_viol, stable_viol, eol_viol, busy_bad);
            end
            checks++;
            if (done_cnt !== 1 || done_cyc !== last_xfer + 1) begin
                errors++; $display("FAIL rand%0d_done got cycle %0d count %0d required cycle %0d count 1",
                                   t, done_cyc, done_cnt, last_xfer + 1);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        m_if.m_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_empty();
        test_reset_mid();
        test_after_reset();
        test_start_ignored();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
